seg_scan_driver: RTL and testbench

Time-multiplexed driver for an N-digit common-anode 7-segment display, generalising the single-digit hex decoder to a scanned multi-digit bank. It latches a packed hex value, scans the digits in turn with a programmable slot period, and inserts anti-ghosting dead time. It also blanks leading zeros, drives per-digit decimal points and updates the display tear-free at frame boundaries. It sits between the system register/counter logic and the board's segment and digit-enable pins.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_scan_driver_hex_to_seg7.sv | 12 +
 rtl/seg_scan_driver.sv | 144 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the scanned 7-segment driver: glyph table, blank pattern, digit limit.
// Combinational constants only; no latency, no flow control.
package seg_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex nibble n.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };

  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_DRIVE = 1'b1
  } slot_state_t;

endpackage

// File: rtl/seg_scan_driver_hex_to_seg7.sv
// Nibble to active-low 7-segment glyph lookup.
// Purely combinational; no flow control.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Scanned multi-digit 7-segment driver with dead time, leading-zero blanking and tear-free frames.
// Outputs registered, 1 cycle behind the scan counters; no backpressure, scan free-runs while EN=1.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 1000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    EN,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
  localparam logic [DW-1:0] D_LAST  = DW'(NUM_DIGITS - 1);
  localparam slot_state_t   SLOT_FIRST = (BLANK_CYC > 0) ? SLOT_BLANK : SLOT_DRIVE;

  logic [PW-1:0]           phase, phase_nxt;
  logic [DW-1:0]           digit, digit_nxt;
  slot_state_t             state, state_nxt;
  logic [4*NUM_DIGITS-1:0] shadow_data, vis_data, cur_data;
  logic [NUM_DIGITS-1:0]   shadow_dp, vis_dp, cur_dp, upper_zero;
  logic                    frame_start;
  logic [3:0]              cur_nibble;
  logic [6:0]              glyph;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;
  logic [NUM_DIGITS-1:0]   sel_nxt;
  logic                    tick_nxt;

  assign frame_start = EN && (phase == '0) && (digit == '0);

  always_comb begin
    phase_nxt = '0;
    digit_nxt = '0;
    if (EN) begin
      phase_nxt = (phase == P_LAST) ? '0 : phase + 1'b1;
      digit_nxt = digit;
      if (phase == P_LAST) begin
        digit_nxt = (digit == D_LAST) ? '0 : digit + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      digit <= '0;
    end else begin
      phase <= phase_nxt;
      digit <= digit_nxt;
    end
  end

  // Slot state tracks the phase counter, so it is derived from the next phase.
  always_ff @(posedge clk) begin
    if (rst) state <= SLOT_FIRST;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = (phase_nxt < P_BLANK) ? SLOT_BLANK : SLOT_DRIVE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      vis_data    <= '0;
      vis_dp      <= '0;
    end else begin
      if (load) begin
        shadow_data <= data_in;
        shadow_dp   <= dp_in;
      end
      if (frame_start) begin
        vis_data <= shadow_data;
        vis_dp   <= shadow_dp;
      end
    end
  end

  // Bypass so the copy cycle already shows the new frame's data (matters when BLANK_CYC=0).
  assign cur_data   = frame_start ? shadow_data : vis_data;
  assign cur_dp     = frame_start ? shadow_dp   : vis_dp;
  assign cur_nibble = cur_data[4*digit +: 4];

  always_comb begin : lz_scan
    logic run_zero;
    run_zero   = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero      = run_zero & (cur_data[4*i +: 4] == 4'h0);
      upper_zero[i] = run_zero;
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (cur_nibble),
    .seg    (glyph)
  );

  always_comb begin
    seg_nxt  = SEG_OFF;
    dp_nxt   = 1'b1;
    sel_nxt  = '1;
    tick_nxt = 1'b0;
    if (EN) begin
      tick_nxt = frame_start;
      if (state == SLOT_DRIVE) begin
        sel_nxt = ~(NUM_DIGITS'(1) << digit);
        seg_nxt = (blank_lz && (digit != '0) && upper_zero[digit]) ? SEG_OFF : glyph;
        dp_nxt  = ~cur_dp[digit];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out    <= SEG_OFF;
      dp_out     <= 1'b1;
      dig_sel    <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= seg_nxt;
      dp_out     <= dp_nxt;
      dig_sel    <= sel_nxt;
      frame_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-time model predicts each output cycle.
module tb_seg_scan_driver;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;

  logic        clk = 1'b0;
  logic        rst, EN, load, blank_lz;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  dig_sel;
  logic        frame_tick;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] sel;
    logic       tick;
  } out_t;

  out_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] m_shadow = '0, m_vis = '0;
  logic [3:0]  m_sdp = '0, m_vdp = '0;
  int          m_t = 0;
  bit          glyph_mode = 1'b0;

  always #5 clk = ~clk;

  seg_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(DIV), .BLANK_CYC(BLK)) dut (
    .clk        (clk),
    .rst        (rst),
    .EN         (EN),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .dig_sel    (dig_sel),
    .frame_tick (frame_tick)
  );

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  // Model: time since scan start gives phase and digit directly.
  task automatic predict();
    out_t e;
    int   p, d;
    e = '{seg: 7'h7f, dp: 1'b1, sel: 4'hf, tick: 1'b0};
    if (rst) begin
      m_shadow = '0; m_vis = '0; m_sdp = '0; m_vdp = '0; m_t = 0;
    end else if (!EN) begin
      m_t = 0;
      if (load) begin m_shadow = data_in; m_sdp = dp_in; end
    end else begin
      p = m_t % DIV;
      d = (m_t / DIV) % N;
      if (p == 0 && d == 0) begin
        m_vis  = m_shadow;
        m_vdp  = m_sdp;
        e.tick = 1'b1;
      end
      if (p >= BLK) begin
        e.sel = ~(4'b0001 << d);
        e.seg = (blank_lz && d > 0 && (m_vis >> (4*d)) == 16'h0) ? 7'h7f
                                                                  : ref_glyph(m_vis[4*d +: 4]);
        e.dp  = ~m_vdp[d];
      end
      m_t++;
      if (load) begin m_shadow = data_in; m_sdp = dp_in; end
    end
    exp_q.push_back(e);
  endtask

  task automatic step();
    out_t e;
    predict();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("seg_out", seg_out, e.seg);
    check("dp_out", dp_out, e.dp);
    check("dig_sel", dig_sel, e.sel);
    check("frame_tick", frame_tick, e.tick);
    if (glyph_mode && dig_sel !== 4'hf) begin
      case (dig_sel)
        4'b1110: check("glyph_12AF_d0", seg_out, 7'b0001110);
        4'b1101: check("glyph_12AF_d1", seg_out, 7'b0001000);
        4'b1011: check("glyph_12AF_d2", seg_out, 7'b0100100);
        4'b0111: check("glyph_12AF_d3", seg_out, 7'b1111001);
        default: check("dig_sel_onecold", dig_sel, 4'hf);
      endcase
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b1; EN = 1'b0; load = 1'b0; blank_lz = 1'b0;
    data_in = '0; dp_in = '0;
    run(3);

    // Basic scan of 12AF
    rst = 1'b0; load = 1'b1; data_in = 16'h12AF; run(1);
    load = 1'b0; EN = 1'b1; glyph_mode = 1'b1; run(64);
    glyph_mode = 1'b0;

    // Leading-zero blanking
    blank_lz = 1'b1; data_in = 16'h0050; load = 1'b1; run(1);
    load = 1'b0; run(70);

    // Tear-free update mid-frame
    blank_lz = 1'b0; data_in = 16'h1111; load = 1'b1; run(1);
    load = 1'b0; run(40);
    data_in = 16'h2222; load = 1'b1; run(1);
    load = 1'b0; run(70);

    // Decimal point on a blanked digit
    blank_lz = 1'b1; data_in = 16'h0003; dp_in = 4'b0100; load = 1'b1; run(1);
    load = 1'b0; run(70);

    // EN dropped mid-slot, re-enabled with a load on the copy cycle
    run(3);
    EN = 1'b0; run(5);
    blank_lz = 1'b0; data_in = 16'h4567; dp_in = 4'b0000; load = 1'b1; EN = 1'b1; run(1);
    load = 1'b0; run(19);

    // Reset during digit 2 DRIVE
    rst = 1'b1; run(1);
    rst = 1'b0; run(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
